// File: rtl/cache_dma_ctrl_primitives.sv
// Control primitives for the cache DMA engine: a clear/up burst counter,
// a binary-to-one-hot way decoder and bit-replicating byte-mask expanders.

module cdp_counter #(
    parameter int max_val_p  = 4,
    parameter int init_val_p = 0,
    parameter int cw_p       = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic            up_i,
    output logic [cw_p-1:0] count_o,
    output logic            max_o
);
    localparam logic [cw_p-1:0] max_c  = cw_p'(max_val_p);
    localparam logic [cw_p-1:0] init_c = cw_p'(init_val_p);
    // clear+up normally lands on init+1; if init already sits at max it wraps like a plain up
    localparam logic [cw_p-1:0] init_up_c = (init_val_p >= max_val_p) ? '0 : cw_p'(init_val_p + 1);

    logic [cw_p-1:0] count_r;
    logic [cw_p-1:0] count_n;

    always_comb begin
        count_n = count_r;
        if (clear_i) begin
            count_n = up_i ? init_up_c : init_c;
        end else if (up_i) begin
            count_n = (count_r == max_c) ? '0 : count_r + cw_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_r <= init_c;
        end else begin
            count_r <= count_n;
        end
    end

    assign count_o = count_r;
    assign max_o   = (count_r == max_c);
endmodule

module cdp_decoder #(
    parameter int num_out_p = 4,
    parameter int sw_p      = 2
) (
    input  logic [sw_p-1:0]      sel_i,
    output logic [num_out_p-1:0] decode_o
);
    if (num_out_p == 1) begin : g_single
        logic unused_sel;
        assign unused_sel = ^sel_i;
        assign decode_o   = 1'b1;
    end else begin : g_multi
        // out-of-range selects match no k and therefore decode to all zeros
        for (genvar k = 0; k < num_out_p; k++) begin : g_bit
            assign decode_o[k] = (sel_i == sw_p'(k));
        end
    end
endmodule

module cdp_expander #(
    parameter int width_p  = 4,
    parameter int expand_p = 8
) (
    input  logic [width_p-1:0]          data_i,
    output logic [width_p*expand_p-1:0] data_o
);
    for (genvar k = 0; k < width_p; k++) begin : g_lane
        assign data_o[k*expand_p +: expand_p] = {expand_p{data_i[k]}};
    end
endmodule

module cache_dma_ctrl_primitives #(
    parameter int max_val_p  = 4,
    parameter int init_val_p = 0,
    parameter int num_out_p  = 4,
    parameter int expand_p   = 8,
    parameter int words_p    = 2,
    localparam int cw_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1),
    localparam int sw_lp = (num_out_p < 2) ? 1 : $clog2(num_out_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          clear_i,
    input  logic                          up_i,
    output logic [cw_lp-1:0]              count_o,
    output logic                          max_o,
    input  logic [sw_lp-1:0]              sel_i,
    output logic [num_out_p-1:0]          decode_o,
    output logic [num_out_p*expand_p-1:0] way_mask_o,
    input  logic [words_p-1:0]            word_mask_i,
    output logic [words_p*expand_p-1:0]   word_mask_o
);
    cdp_counter #(
        .max_val_p (max_val_p),
        .init_val_p(init_val_p),
        .cw_p      (cw_lp)
    ) u_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(clear_i),
        .up_i   (up_i),
        .count_o(count_o),
        .max_o  (max_o)
    );

    cdp_decoder #(
        .num_out_p(num_out_p),
        .sw_p     (sw_lp)
    ) u_decoder (
        .sel_i   (sel_i),
        .decode_o(decode_o)
    );

    cdp_expander #(
        .width_p (num_out_p),
        .expand_p(expand_p)
    ) u_way_expander (
        .data_i(decode_o),
        .data_o(way_mask_o)
    );

    cdp_expander #(
        .width_p (words_p),
        .expand_p(expand_p)
    ) u_word_expander (
        .data_i(word_mask_i),
        .data_o(word_mask_o)
    );
endmodule

// File: tb/tb_cache_dma_ctrl_primitives.sv
// Bench for cache_dma_ctrl_primitives: directed checks then randomized traffic
// compared against an arithmetic reference model.

module tb_cache_dma_ctrl_primitives;
    localparam int MAXV  = 4;
    localparam int INITV = 0;
    localparam int NOUT  = 4;
    localparam int EXPN  = 8;
    localparam int WORDS = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clear_i;
    logic        up_i;
    logic [2:0]  count_o;
    logic        max_o;
    logic [1:0]  sel_i;
    logic [3:0]  decode_o;
    logic [31:0] way_mask_o;
    logic [1:0]  word_mask_i;
    logic [15:0] word_mask_o;

    int checks   = 0;
    int failures = 0;
    int model_cnt;

    always #5 clk_i = ~clk_i;

    cache_dma_ctrl_primitives #(
        .max_val_p (MAXV),
        .init_val_p(INITV),
        .num_out_p (NOUT),
        .expand_p  (EXPN),
        .words_p   (WORDS)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (clear_i),
        .up_i       (up_i),
        .count_o    (count_o),
        .max_o      (max_o),
        .sel_i      (sel_i),
        .decode_o   (decode_o),
        .way_mask_o (way_mask_o),
        .word_mask_i(word_mask_i),
        .word_mask_o(word_mask_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_decode(input int sel);
        ref_decode = (sel < NOUT) ? (32'd1 << sel) : 32'd0;
    endfunction

    function automatic logic [31:0] ref_expand(input logic [31:0] bits, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < EXPN; b++)
                if (bits[k]) r[k*EXPN + b] = 1'b1;
        return r;
    endfunction

    // One clock: apply controls, let the edge happen, update the model, check just after.
    task automatic cycle(input logic clr, input logic up, input string tag);
        clear_i = clr;
        up_i    = up;
        @(posedge clk_i);
        if (!reset_i)   model_cnt = INITV;
        else if (clr)   model_cnt = (INITV + int'(up)) % (MAXV + 1);
        else if (up)    model_cnt = (model_cnt + 1) % (MAXV + 1);
        #1;
        chk({tag, "_count"}, 32'(count_o), 32'(model_cnt));
        chk({tag, "_max"}, 32'(max_o), 32'(model_cnt == MAXV));
    endtask

    task automatic comb(input int sel, input int wm, input string tag);
        sel_i       = 2'(sel);
        word_mask_i = 2'(wm);
        #1;
        chk({tag, "_decode"}, 32'(decode_o), ref_decode(sel));
        chk({tag, "_way"}, way_mask_o, ref_expand(ref_decode(sel), NOUT));
        chk({tag, "_word"}, 32'(word_mask_o), ref_expand(32'(wm), WORDS));
    endtask

    initial begin
        reset_i = 1'b0; clear_i = 1'b0; up_i = 1'b0;
        sel_i = '0; word_mask_i = '0;
        model_cnt = INITV;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_count", 32'(count_o), 32'(INITV));
        chk("reset_max", 32'(max_o), 32'd0);
        reset_i = 1'b1;

        cycle(0, 1, "up1"); cycle(0, 1, "up2"); cycle(0, 1, "up3");
        chk("count_is_3", 32'(count_o), 32'd3);
        cycle(1, 1, "clear_up");
        chk("clear_up_is_1", 32'(count_o), 32'd1);
        cycle(1, 0, "clear");
        for (int i = 0; i < 4; i++) cycle(0, 1, "ramp");
        chk("at_max", 32'(max_o), 32'd1);
        cycle(0, 1, "wrap");
        chk("wrap_is_0", 32'(count_o), 32'd0);
        cycle(0, 1, "r1"); cycle(0, 1, "r2");
        cycle(0, 0, "hold");
        cycle(1, 0, "clear_from_2");
        chk("clear_from_2_is_0", 32'(count_o), 32'd0);

        // async reset mid-count with up held
        for (int i = 0; i < 3; i++) cycle(0, 1, "pre_rst");
        up_i = 1'b1;
        #2 reset_i = 1'b0;
        #1 chk("async_rst_now", 32'(count_o), 32'(INITV));
        model_cnt = INITV;
        cycle(0, 1, "in_rst_a");
        cycle(1, 1, "in_rst_b");
        reset_i = 1'b1;
        cycle(0, 1, "post_rst");

        comb(2, 2, "sel2"); comb(0, 3, "sel0");
        comb(1, 0, "sel1"); comb(3, 1, "sel3");
        chk("way_sel3", way_mask_o, 32'hFF00_0000);

        for (int it = 0; it < 400; it++) begin
            comb(int'($urandom_range(3)), int'($urandom_range(3)), "rnd_comb");
            if ($urandom_range(31) == 0) begin
                #1 reset_i = 1'b0;
                #1 chk("rnd_async_rst", 32'(count_o), 32'(INITV));
                model_cnt = INITV;
                cycle(1'($urandom_range(1)), 1'($urandom_range(1)), "rnd_in_rst");
                reset_i = 1'b1;
            end
            cycle(($urandom_range(7) == 0), 1'($urandom_range(1)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
